// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared register-file writeback widths, zero register and requester limit.
package rf_wb_arbiter_pkg;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ZERO_REG = 5'd0;
  localparam int RF_WB_MAX_REQ = 4;
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: per-requester valid/ready writeback bus plus the shared RF write port.
interface rf_wb_arbiter_if import rf_wb_arbiter_pkg::*; #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          hold;
  logic                          rf_write_enable;
  logic [ADDR_WIDTH-1:0]         rf_write_addr;
  logic [DATA_WIDTH-1:0]         rf_write_data;
  logic                          pending_valid;
  logic [ADDR_WIDTH-1:0]         pending_addr;
  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready, rf_write_enable, rf_write_addr, rf_write_data, pending_valid, pending_addr
  );
  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready, rf_write_enable, rf_write_addr, rf_write_data, pending_valid, pending_addr
  );
endinterface

// File: rtl/rf_wb_rr_picker.sv
// rf_wb_rr_picker: one-hot grant from valid; round-robin from a pointer under RF_WB_RR_EN, else fixed priority.
module rf_wb_rr_picker import rf_wb_arbiter_pkg::*; #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]                 i_valid,
`ifdef RF_WB_RR_EN
  input  logic [ptr_width(NUM_REQ)-1:0]      i_ptr,
`endif
  output logic [NUM_REQ-1:0]                 o_grant
);
`ifdef RF_WB_RR_EN
  // Scan farthest-first so the requester nearest the pointer overwrites the others.
  always_comb begin
    o_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (i_valid[(int'(i_ptr) + k) % NUM_REQ]) o_grant = NUM_REQ'(1) << ((int'(i_ptr) + k) % NUM_REQ);
  end
`else
  assign o_grant = i_valid & (~i_valid + NUM_REQ'(1));
`endif
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the RF write port among NUM_REQ requesters through a registered output stage.
// RF_WB_RR_EN selects round-robin arbitration; otherwise the lowest valid index always wins.
module rf_wb_arbiter import rf_wb_arbiter_pkg::*; #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input logic           clk,
  input logic           reset,
  rf_wb_arbiter_if.slave bus
);
  localparam int PW = ptr_width(NUM_REQ);
  logic [NUM_REQ-1:0]    w_valid;
  logic [NUM_REQ-1:0]    w_grant;
  logic [PW-1:0]         w_idx;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  assign w_valid = bus.hold ? '0 : bus.req_valid;
  assign w_xfer  = |w_grant;
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_grant[i]) w_idx = PW'(i);
  end
  assign w_addr = bus.req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_data = bus.req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
`ifdef RF_WB_RR_EN
  logic [PW-1:0] r_ptr;
  rf_wb_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (.i_valid(w_valid), .i_ptr(r_ptr), .o_grant(w_grant));
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ptr <= '0;
    else if (w_xfer) r_ptr <= (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
`else
  rf_wb_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (.i_valid(w_valid), .o_grant(w_grant));
`endif
  // Writes to the zero register complete the handshake but never enable the RF; addr/data still load for debug.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_xfer && (w_addr != ADDR_WIDTH'(RF_ZERO_REG));
      if (w_xfer) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  assign bus.req_ready       = w_grant;
  assign bus.rf_write_enable = r_we;
  assign bus.rf_write_addr   = r_addr;
  assign bus.rf_write_data   = r_data;
  assign bus.pending_valid   = r_we;
  assign bus.pending_addr    = r_addr;
endmodule
